alsu_result_collector: RTL and testbench

//  Downstream stage of the ALSU. Captures each valid ALSU result (6-bit signed out plus the 16-bit leds

---
 rtl/alsu_result_collector.sv | 172 +++++++++++++++++
 tb/tb_alsu_result_collector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alsu_result_collector.sv
// Result collector behind the ALSU: buffers each valid result with its error flag in a small FIFO
// and hands it to a consumer over valid/ready. Optional running sum enabled by ALSU_COLLECT_ACC_EN.
module alsu_result_collector #(
    parameter int DATA_W    = 6,
    parameter int DEPTH     = 8,
    parameter int ERR_CNT_W = 8,
    parameter int ACC_W     = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_out,
    input  logic [15:0]                in_leds,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_err,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [ERR_CNT_W-1:0]       err_cnt,
    output logic [ACC_W-1:0]           acc
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_W + 1;

    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(DEPTH);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

    // Storage entry layout: {err, data}
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic [DATA_W-1:0]    head_data_reg, head_data_next;
    logic                 head_err_reg, head_err_next;
    logic                 overflow_reg, overflow_next;
    logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;

    logic               in_err;
    logic               full_int;
    logic               empty_int;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] rd_entry;

    assign in_err    = |in_leds;
    assign in_entry  = {in_err, in_out};
    assign full_int  = (count_reg == CNT_FULL);
    assign empty_int = (count_reg == '0);
    assign pop       = !empty_int && m_ready;
    assign push      = in_valid && (!full_int || pop);
    assign rd_entry  = mem[rd_ptr_next];

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        head_data_next = head_data_reg;
        head_err_next  = head_err_reg;
        overflow_next  = overflow_reg;
        err_cnt_next   = err_cnt_reg;

        if (clr) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            head_data_next = '0;
            head_err_next  = 1'b0;
            overflow_next  = 1'b0;
            err_cnt_next   = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase

            if (in_valid && full_int && !pop) begin
                overflow_next = 1'b1;
            end
            if (in_valid && in_err && (err_cnt_reg != ERR_MAX)) begin
                err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
            end

            // Head register tracks the next head entry; if that slot is being written this cycle
            // the array still holds stale contents, so take the incoming entry instead.
            if (count_next != '0) begin
                if (push && (count_reg == CNT_W'(pop))) begin
                    head_data_next = in_out;
                    head_err_next  = in_err;
                end else begin
                    head_data_next = rd_entry[DATA_W-1:0];
                    head_err_next  = rd_entry[DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr_reg] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            head_data_reg <= '0;
            head_err_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            head_data_reg <= head_data_next;
            head_err_reg  <= head_err_next;
            overflow_reg  <= overflow_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

`ifdef ALSU_COLLECT_ACC_EN
    logic [ACC_W-1:0] acc_reg, acc_next;

    always_comb begin
        acc_next = acc_reg;
        if (clr) begin
            acc_next = '0;
        end else if (push && !in_err) begin
            acc_next = acc_reg + ACC_W'($signed(in_out));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    assign acc = acc_reg;
`else
    assign acc = '0;
`endif

    assign m_valid  = !empty_int;
    assign m_data   = head_data_reg;
    assign m_err    = head_err_reg;
    assign count    = count_reg;
    assign full     = full_int;
    assign empty    = empty_int;
    assign overflow = overflow_reg;
    assign err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_alsu_result_collector.sv
// Directed bench for alsu_result_collector: a default instance plus a narrow one
// (ERR_CNT_W=2, ACC_W=6) fed the same stimulus for saturation and wrap cases.
module tb_alsu_result_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [5:0]  in_out;
    logic [15:0] in_leds;
    logic        m_ready;

    logic        m_valid, m_err, full, empty, overflow;
    logic [5:0]  m_data;
    logic [3:0]  count;
    logic [7:0]  err_cnt;
    logic [11:0] acc;

    logic        s_m_valid, s_m_err, s_full, s_empty, s_overflow;
    logic [5:0]  s_m_data;
    logic [3:0]  s_count;
    logic [1:0]  s_err_cnt;
    logic [5:0]  s_acc;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alsu_result_collector dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_out(in_out),
        .in_leds(in_leds), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_err(m_err), .count(count), .full(full), .empty(empty), .overflow(overflow),
        .err_cnt(err_cnt), .acc(acc)
    );

    alsu_result_collector #(.ERR_CNT_W(2), .ACC_W(6)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_out(in_out),
        .in_leds(in_leds), .m_valid(s_m_valid), .m_ready(m_ready), .m_data(s_m_data),
        .m_err(s_m_err), .count(s_count), .full(s_full), .empty(s_empty),
        .overflow(s_overflow), .err_cnt(s_err_cnt), .acc(s_acc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-16s got=%0h", tag, got);
        end else begin
            $display("FAIL %-16s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] v, input logic [15:0] leds);
        in_valid = 1'b1;
        in_out   = v;
        in_leds  = leds;
        tick();
        in_valid = 1'b0;
        in_leds  = '0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        logic [5:0] exp_v;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_out = '0; in_leds = '0; m_ready = 1'b0;
        tick();
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_mdata", m_data, 0);
        check("rst_acc", acc, 0);
        rst_n = 1'b1;
        tick();

        // 1: asynchronous reset mid-stream
        push(6'd1, 16'h0001);
        push(6'd2, 16'h0000);
        push(6'd3, 16'h0000);
        check("t1_count", count, 3);
        check("t1_errcnt", err_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_empty", empty, 1);
        check("t1_async_count", count, 0);
        check("t1_async_mvalid", m_valid, 0);
        check("t1_async_errcnt", err_cnt, 0);
        check("t1_async_ovf", overflow, 0);
        rst_n = 1'b1;
        tick();

        // 2: ordering
        push(6'd5, 16'h0);
        check("t2_latency", m_valid, 1);
        push(6'h3D, 16'h0);
        push(6'h1F, 16'h0);
        push(6'h20, 16'h0);
        check("t2_count", count, 4);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: exp_v = 6'd5;
                1: exp_v = 6'h3D;
                2: exp_v = 6'h1F;
                default: exp_v = 6'h20;
            endcase
            check("t2_pop_data", m_data, exp_v);
            check("t2_pop_err", m_err, 0);
            check("t2_pop_count", count, 4 - i);
            tick();
        end
        m_ready = 1'b0;
        check("t2_drained", empty, 1);
        check("t2_hold_last", m_data, 6'h20);

        // 3: fill and overflow
        for (int i = 1; i <= 8; i++) push(6'(i), 16'h0);
        check("t3_full", full, 1);
        check("t3_no_ovf", overflow, 0);
        push(6'd9, 16'h0);
        check("t3_ovf", overflow, 1);
        check("t3_count", count, 8);
        check("t3_head", m_data, 6'd1);

        // 4: push + pop while full
        m_ready = 1'b1;
        push(6'd20, 16'h0);
        m_ready = 1'b0;
        check("t4_count", count, 8);
        check("t4_ovf", overflow, 1);
        check("t4_head", m_data, 6'd2);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_v = (i < 7) ? 6'(i + 2) : 6'd20;
            check("t4_drain", m_data, exp_v);
            tick();
        end
        m_ready = 1'b0;
        check("t4_empty", empty, 1);
        do_clr();
        check("clr_ovf", overflow, 0);
        check("clr_mdata", m_data, 0);

        // 5: error flag and saturation
        push(6'd0, 16'hFFFF);
        push(6'd7, 16'h0000);
        check("t5_err_head", m_err, 1);
        check("t5_err_data", m_data, 0);
        check("t5_errcnt", err_cnt, 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("t5_good_err", m_err, 0);
        check("t5_good_data", m_data, 6'd7);
        for (int i = 0; i < 4; i++) push(6'd1, 16'h0010);
        check("t5_errcnt5", err_cnt, 5);
        check("t5_errcnt_sat", s_err_cnt, 3);
        do_clr();
        check("clr_errcnt", err_cnt, 0);
        check("clr_count", count, 0);

        // 6: accumulator
        push(6'h1F, 16'h0);
        push(6'h1F, 16'h0);
        push(6'h20, 16'h0);
        push(6'd10, 16'h0001);
`ifdef ALSU_COLLECT_ACC_EN
        check("t6_acc", acc, 12'd30);
        check("t6_acc_s", s_acc, 6'd30);
`else
        check("t6_acc_off", acc, 0);
        check("t6_acc_s_off", s_acc, 0);
`endif
        do_clr();
        check("t6_clr_acc", acc, 0);

        // ready on empty FIFO must not underflow
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("t6_undf_count", count, 0);
        check("t6_undf_mvalid", m_valid, 0);
        push(6'h1F, 16'h0);
        push(6'd1, 16'h0);
        check("t6_head", m_data, 6'h1F);
        check("t6_count", count, 2);
`ifdef ALSU_COLLECT_ACC_EN
        check("t6_acc32", acc, 12'd32);
        check("t6_acc_wrap", s_acc, 6'h20);
`else
        check("t6_acc_off2", acc, 0);
        check("t6_acc_s_off2", s_acc, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
